sram_controller: RTL and testbench
==================================

Name: sram_controller

Overview:
- SRAM bus initiator inside `arm`, between the MEM stage and the external 16-bit asynchronous SRAM (`sram` model in simulation).
- Converts one 32-bit word read/write per request into two sequential 16-bit SRAM accesses: low half first, then high half.
- Holds `ready` low to freeze the pipeline until the word access completes.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- ACCESS_CYCLES, 2: cycles each 16-bit half-access is held on the bus (≥1).

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  MEM-stage store request
- rd_en  in  1  MEM-stage load request
- address  in  32  byte address from ALU result
- write_data  in  32  store data (val_rm)
- read_data  out  32  load result
- ready  out  1  0 = freeze pipeline
- sram_dq  inout  16  SRAM data bus
- sram_addr  out  18  SRAM half-word address
- sram_we_n  out  1  active-low write strobe
- sram_oe_n  out  1  active-low output enable
- sram_ce_n, sram_ub_n, sram_lb_n  out  1 each  tied 0

Behaviour:
- States: IDLE, LO, HI, DONE. 2-bit counter `cnt` runs in LO/HI.
- IDLE, no request:
  - `ready`=1.
  - SRAM bus idle: `sram_we_n`=1, `sram_oe_n`=1, `sram_dq` high-Z, `sram_addr`=0.
- IDLE with `wr_en|rd_en`:
  - `ready`=0.
  - Latch op, `address`, and `write_data`.
  - Write has priority when both enables are high.
  - Next state LO, `cnt`=0.
- Address mapping: `idx` = (`address` − BASE_ADDR)[18:2], truncated to 17 bits.
  - LO drives `sram_addr`={`idx`,1'b0}.
  - HI drives `sram_addr`={`idx`,1'b1}.
- LO/HI, write:
  - `sram_we_n`=0, `sram_oe_n`=1.
  - `sram_dq` driven with latched data [15:0] in LO, [31:16] in HI.
- LO/HI, read:
  - `sram_we_n`=1, `sram_oe_n`=0, `sram_dq` high-Z.
  - `sram_dq` is captured into `read_data`[15:0] on the last LO cycle and into `read_data`[31:16] on the last HI cycle.
- Each of LO and HI lasts exactly ACCESS_CYCLES cycles, then advances: LO→HI→DONE.
- DONE:
  - `ready`=1, bus idle.
  - Lasts one cycle, then IDLE.
  - The pipeline advances on this edge; MEM/WB registers the word here.
- `ready` is combinational: 0 in LO and HI, and 0 in IDLE when a request is present; 1 otherwise.
- `ready`-low cycles per access = 1 + 2·ACCESS_CYCLES (5 at default).
- Latched request is immune to input changes after IDLE; deasserting enables mid-access does not abort it.
- `read_data` holds its value until the next read updates it. Writes never alter `read_data`.
- Back-to-back: a request present in the IDLE cycle following DONE starts immediately. No extra bubble beyond DONE→IDLE.
- Address below BASE_ADDR wraps modulo 2^17 words. No error flag.
- Reset, including mid-access:
  - Next edge: state IDLE, `cnt`=0, `read_data`=0, `sram_we_n`=1, `sram_oe_n`=1, `sram_dq` high-Z, `sram_addr`=0.
  - `ready` then follows the IDLE rule.
  - A partial write may leave only the low half updated. This is accepted.

Test Plan:
- Write 0xDEADBEEF to address 1024 → `sram_addr`=0 with `dq`=0xBEEF and `we_n`=0 for 2 cycles, then `sram_addr`=1 with `dq`=0xDEAD for 2 cycles; `ready` low for exactly 5 cycles, high in DONE.
- Read address 1024 after that write → `oe_n`=0, `we_n`=1, `dq` released; `read_data`=0xDEADBEEF in DONE cycle and held afterwards.
- Write 0x12345678 to 1028 then read 1028 and 1024 back-to-back → `sram_addr` 2/3 used, reads return 0x12345678 and 0xDEADBEEF, no idle cycles between requests beyond DONE.
- `wr_en`=`rd_en`=1, address 1032, `write_data`=0xCAFEF00D → write performed (`we_n` pulses, `sram_addr` 4/5), `read_data` unchanged.
- Drop `wr_en` during LO of a write → access completes both halves, `ready` pattern unchanged.
- Assert `rst` in the HI state of a write → next cycle `we_n`=1, `dq` high-Z, `read_data`=0, `ready`=1 with enables low; subsequent write to 1024 completes normally in 5 stall cycles.

Source files
------------

// File: rtl/sram_controller.sv
// sram_controller: 32-bit word bus initiator for a 16-bit asynchronous SRAM.
// Each MEM-stage request is split into two 16-bit half-accesses: low half, then high half.
// Each half-access is held on the bus for ACCESS_CYCLES cycles. ready stays low until the
// word is complete, which freezes the pipeline.
//
// Ports:
//   clk, rst          system clock; synchronous active-high reset
//   wr_en, rd_en      store / load request from MEM (write wins if both are set)
//   address           byte address; BASE_ADDR maps to SRAM word 0
//   write_data        store data
//   read_data         load result, held until the next read completes
//   ready             0 = freeze pipeline
//   sram_*            external SRAM bus (ce/ub/lb tied active)
module sram_controller #(
  parameter int unsigned BASE_ADDR     = 1024,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] sram_dq,
  output logic [17:0] sram_addr,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ce_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  localparam logic [1:0] LastCnt = 2'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic        op_wr_q;
  logic [16:0] idx_q;
  logic [15:0] data_hi_q;
  logic        dq_oe_q;
  logic [15:0] dq_out_q;

  logic [31:0] offset;
  logic [16:0] idx;
  logic        req;
  logic        unused_offset;

  // Addresses below BASE_ADDR wrap modulo 2^17 words.
  assign offset        = address - BASE_ADDR;
  assign idx           = offset[18:2];
  assign unused_offset = ^{offset[31:19], offset[1:0]};
  assign req           = wr_en | rd_en;

  assign ready   = !((state_q == StLo) || (state_q == StHi) || ((state_q == StIdle) && req));
  assign sram_dq = dq_oe_q ? dq_out_q : 16'hzzzz;

  assign sram_ce_n = 1'b0;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

  // Bus outputs are registered: each transition loads the values for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 2'd0;
      op_wr_q   <= 1'b0;
      idx_q     <= 17'd0;
      data_hi_q <= 16'd0;
      read_data <= 32'd0;
      sram_addr <= 18'd0;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
      dq_oe_q   <= 1'b0;
      dq_out_q  <= 16'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            state_q   <= StLo;
            cnt_q     <= 2'd0;
            op_wr_q   <= wr_en;
            idx_q     <= idx;
            data_hi_q <= write_data[31:16];
            sram_addr <= {idx, 1'b0};
            sram_we_n <= ~wr_en;
            sram_oe_n <= wr_en;
            dq_oe_q   <= wr_en;
            dq_out_q  <= write_data[15:0];
          end
        end
        StLo: begin
          if (cnt_q == LastCnt) begin
            if (!op_wr_q) begin
              read_data[15:0] <= sram_dq;
            end
            state_q   <= StHi;
            cnt_q     <= 2'd0;
            sram_addr <= {idx_q, 1'b1};
            dq_out_q  <= data_hi_q;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        StHi: begin
          if (cnt_q == LastCnt) begin
            if (!op_wr_q) begin
              read_data[31:16] <= sram_dq;
            end
            state_q   <= StDone;
            cnt_q     <= 2'd0;
            sram_addr <= 18'd0;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            dq_oe_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

  localparam int unsigned Base = 1024;
  localparam int unsigned Acc  = 2;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        sram_ce_n;
  logic        sram_ub_n;
  logic        sram_lb_n;

  sram_controller #(
    .BASE_ADDR    (Base),
    .ACCESS_CYCLES(Acc)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .ready     (ready),
    .sram_dq   (sram_dq),
    .sram_addr (sram_addr),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n),
    .sram_ce_n (sram_ce_n),
    .sram_ub_n (sram_ub_n),
    .sram_lb_n (sram_lb_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small asynchronous SRAM model, indexed by the low address bits.
  logic [15:0] sram_mem [0:255];
  assign sram_dq = !sram_oe_n ? sram_mem[sram_addr[7:0]] : 16'hzzzz;
  always @(posedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr[7:0]] <= sram_dq;
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] last_rd;
  logic [31:0] sb [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_read(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'd0;
  endfunction

  // One full word access starting in an IDLE cycle (inputs driven just after a rising edge).
  // hold=1 keeps the enables up and scrambles address/data during the access.
  // rst_at>0 asserts reset at that ready-low cycle instead of completing the access.
  task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input bit hold, input int rst_at);
    logic [16:0] idx;
    logic [31:0] off;
    int          stall;
    bit          done;
    logic        half;
    off = a - Base;
    idx = off[18:2];
    if (rst_at == 0) begin
      if (wr) begin
        ref_mem[int'(idx)] = d;
        sb.push_back(last_rd);
      end else begin
        last_rd = ref_read(int'(idx));
        sb.push_back(last_rd);
      end
    end
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    stall = 0;
    done  = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (ready) begin
        done = 1;
        check("stall_cycles", 64'(stall), 64'd5);
        check("read_data", read_data, sb.pop_front());
        check("bus_idle_done", {sram_we_n, sram_oe_n, sram_addr}, {1'b1, 1'b1, 18'd0});
        wr_en = 0; rd_en = 0;
      end else begin
        stall++;
        if (stall > 1) begin
          half = (stall > 1 + Acc);
          check("bus", {sram_we_n, sram_oe_n, sram_addr}, {~wr, wr, idx, half});
          if (wr) check("dq", sram_dq, half ? d[31:16] : d[15:0]);
        end
        if (rst_at > 0 && stall == rst_at) begin
          rst = 1;
          @(posedge clk); #1;
          rst = 0; wr_en = 0; rd_en = 0;
          @(negedge clk);
          check("rst_ready", ready, 1'b1);
          check("rst_bus", {sram_we_n, sram_oe_n, sram_addr}, {1'b1, 1'b1, 18'd0});
          check("rst_read_data", read_data, 32'd0);
          last_rd = 32'd0;
          done = 1;
        end else begin
          @(posedge clk); #1;
          if (stall == 1) begin
            if (hold) begin
              address = $urandom; write_data = $urandom;
            end else begin
              wr_en = 0; rd_en = 0;
            end
          end
        end
      end
    end
    if (!done) check("timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; wr_en = 0; rd_en = 0; address = 0; write_data = 0;
    last_rd = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_ready", ready, 1'b1);
    check("reset_bus", {sram_we_n, sram_oe_n, sram_addr}, {1'b1, 1'b1, 18'd0});
    check("reset_read_data", read_data, 32'd0);
    check("tied_strobes", {sram_ce_n, sram_ub_n, sram_lb_n}, 3'b000);
    @(posedge clk); #1;

    access(1, 0, 32'd1024, 32'hDEADBEEF, 0, 0);
    access(0, 1, 32'd1024, 32'h0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("read_data_held", read_data, 32'hDEADBEEF);

    // Back-to-back: next request presented in the IDLE cycle right after DONE.
    access(1, 0, 32'd1028, 32'h12345678, 0, 0);
    access(0, 1, 32'd1028, 32'h0, 0, 0);
    access(0, 1, 32'd1024, 32'h0, 0, 0);

    // Both enables: write wins, read_data untouched.
    access(1, 1, 32'd1032, 32'hCAFEF00D, 0, 0);
    access(0, 1, 32'd1032, 32'h0, 0, 0);

    // Inputs change mid-access; latched request must be used.
    access(1, 0, 32'd1036, 32'h0F1E2D3C, 1, 0);
    access(0, 1, 32'd1036, 32'h0, 1, 0);

    // Below BASE_ADDR wraps to the top word.
    access(1, 0, 32'd1020, 32'hA5A55A5A, 0, 0);
    access(0, 1, 32'd1020, 32'h0, 0, 0);

    // Reset during the first HI cycle of a write, then normal traffic.
    access(1, 0, 32'd1028, 32'h77778888, 0, 2 + Acc);
    access(1, 0, 32'd1024, 32'h0BADCAFE, 0, 0);
    access(0, 1, 32'd1024, 32'h0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
